dmem_responder: RTL

- Responder end of the CPU data-memory interface: services load/store requests from the datapath's memory stage over a valid/ready request channel plus a one-cycle response pulse.
- Replaces the zero-wait data memory with a multi-cycle storage target that has configurable wait states.
- Lets the core and future cache/stall logic be exercised against realistic memory latency.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_array.sv | 30 +++
 rtl/dmem_responder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the multi-cycle data-memory responder.
package dmem_pkg;

    // Width of the wait-state counter; holds LATENCY-1 for LATENCY up to 15.
    localparam int CNT_W = 4;

    // Responder sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // A request is bad if it is not word aligned or lies beyond the array.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned aw);
        logic [31:0] upper;
        upper = addr >> (aw + 2);
        return (addr[1:0] != 2'b00) || (upper != 32'd0);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage with byte-enable write and registered read.
module dmem_array #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [3:0]            be_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    logic [31:0] mem_q [2**ADDR_WIDTH];

    // Port access happens only on the commit strobe; contents are never reset.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int i = 0; i < 4; i++) begin
                    if (be_i[i]) begin
                        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                    end
                end
            end
            rdata_o <= mem_q[addr_i];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the data-memory interface with LATENCY wait states.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic              resp_valid_q;
    logic              resp_err_q;
    logic              rd_sel_q;

    logic              accept;
    logic              commit;
    logic              commit_en;
    logic              c_write;
    logic [31:0]       c_addr;
    logic [31:0]       c_wdata;
    logic [3:0]        c_be;
    logic              c_err;
    logic [31:0]       arr_rdata;

    assign accept    = (state_q == ST_IDLE) && req_valid;
    assign req_ready = (state_q == ST_IDLE);

    // Next-state and counter logic; commit flags the edge that enters RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    cnt_d = LAT_M1;
                    if (LATENCY > 1) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_RESP;
                        commit  = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_RESP;
                    commit  = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // With a single-cycle latency the commit coincides with the accept edge,
    // so the live request inputs are used instead of the captured copy.
    always_comb begin
        if (state_q == ST_IDLE) begin
            c_write = req_write;
            c_addr  = req_addr;
            c_wdata = req_wdata;
            c_be    = req_be;
        end else begin
            c_write = wr_q;
            c_addr  = addr_q;
            c_wdata = wdata_q;
            c_be    = be_q;
        end
    end

    assign c_err     = addr_err(c_addr, ADDR_WIDTH);
    assign commit_en = commit && !rst;

    dmem_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk     (clk),
        .en_i    (commit_en && !c_err),
        .we_i    (c_write),
        .be_i    (c_be),
        .addr_i  (c_addr[ADDR_WIDTH+1:2]),
        .wdata_i (c_wdata),
        .rdata_o (arr_rdata)
    );

    // FSM, request capture and response flags; reset discards any pending request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rd_sel_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= commit;
            if (accept) begin
                wr_q    <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
            if (commit) begin
                resp_err_q <= c_err;
                rd_sel_q   <= !c_write && !c_err;
            end else if (state_q == ST_RESP) begin
                resp_err_q <= 1'b0;
                rd_sel_q   <= 1'b0;
            end
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = rd_sel_q ? arr_rdata : 32'd0;

endmodule
